// File: rtl/scsp_midi_tx.sv
// SCSP MIDI output transmitter: MOBUF byte FIFO drained by a 31.25 kbaud 8N1 serializer.
// Reports FIFO empty/full status, overflow and an empty interrupt to the register file.
module scsp_midi_tx #(
  parameter int CLK_DIV    = 722,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       WR,
  input  logic [7:0] DI,
  output logic       TXD,
  output logic       OE,
  output logic       OF,
  output logic       BUSY,
  output logic       OVR,
  output logic       EMPTY_IRQ
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [11:0]   BAUD_LAST = 12'(CLK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic [1:0]  state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [11:0] baud;

  logic pop;
  logic push;
  logic drop;

  // A pop happens when the line is free: from IDLE, or at the very end of a stop bit
  // so that queued frames follow each other with no idle gap.
  assign pop  = CE && (count != '0) &&
                ((state == IDLE) || ((state == STOP) && (baud == BAUD_LAST)));
  assign push = WR && ((count != FULL) || pop);
  assign drop = WR && (count == FULL) && !pop;

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= DI;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      baud    <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        shift <= mem[rptr];
        baud  <= '0;
        state <= START;
      end
    end else if (CE) begin
      if (baud != BAUD_LAST) begin
        baud <= baud + 12'd1;
      end else begin
        baud <= '0;
        case (state)
          START: begin
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            shift <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) state <= STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          default: begin
            if (pop) begin
              shift <= mem[rptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  // Status and line outputs trail the state they describe by one clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TXD       <= 1'b1;
      OE        <= 1'b1;
      OF        <= 1'b0;
      OVR       <= 1'b0;
      EMPTY_IRQ <= 1'b0;
    end else begin
      TXD       <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
      OE        <= (count == '0);
      OF        <= (count == FULL);
      OVR       <= drop;
      EMPTY_IRQ <= (count == '0) && !OE;
    end
  end

  assign BUSY = (state != IDLE);

endmodule
